// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: ps2c glitch filter, 11-bit frame checker, receive FIFO.
// Optional inter-bit watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_ps2d,
  input  logic                          i_ps2c,
  input  logic                          i_rx_en,
  output logic                          o_rx_idle,
  output logic [7:0]                    o_dout,
  output logic                          o_dout_valid,
  input  logic                          i_dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_err_parity,
  output logic                          o_err_frame,
  output logic                          o_err_overflow,
  output logic                          o_err_timeout
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DPS, S_CHECK} state_t;

  state_t                r_state, w_state_next;
  logic [FILTER_LEN-1:0] r_filt_sh;
  logic                  r_filt, w_filt_next, w_fall;
  logic [10:0]           r_shift, w_shift_next;
  logic [3:0]            r_bitcnt, w_bitcnt_next;
  logic                  w_frame_err, w_par_err, w_push_req, w_wd_expire;
  logic                  r_err_parity, r_err_frame, r_err_overflow;

  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  w_full, w_push, w_pop;

  // Filtered clock only changes once the whole window agrees.
  always_comb begin
    w_filt_next = r_filt;
    if (&r_filt_sh)       w_filt_next = 1'b1;
    else if (~|r_filt_sh) w_filt_next = 1'b0;
  end
  assign w_fall = r_filt & ~w_filt_next;

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_frame_err   = 1'b0;
    w_par_err     = 1'b0;
    w_push_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && i_rx_en) begin
          w_shift_next  = {i_ps2d, r_shift[10:1]};
          w_bitcnt_next = 4'd9;
          w_state_next  = S_DPS;
        end
      end
      S_DPS: begin
        if (w_fall) begin
          w_shift_next = {i_ps2d, r_shift[10:1]};
          if (r_bitcnt == 4'd0) w_state_next = S_CHECK;
          else                  w_bitcnt_next = r_bitcnt - 4'd1;
        end else if (w_wd_expire) begin
          w_state_next = S_IDLE;
        end
      end
      S_CHECK: begin
        w_state_next = S_IDLE;
        if (r_shift[0] || !r_shift[10])   w_frame_err = 1'b1;
        else if ((^r_shift[9:1]) == 1'b0) w_par_err   = 1'b1;
        else                              w_push_req  = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int                WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] r_wd;
  logic            w_wd_clr;
  logic            r_err_timeout;

  assign w_wd_clr    = w_fall && ((r_state == S_IDLE && i_rx_en) || r_state == S_DPS);
  assign w_wd_expire = (r_state == S_DPS) && !w_fall && (r_wd == WD_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wd          <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_wd_expire;
      if (w_wd_clr)               r_wd <= '0;
      else if (r_state == S_DPS)  r_wd <= r_wd + 1'b1;
    end
  end
  assign o_err_timeout = r_err_timeout;
`else
  assign w_wd_expire   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign w_full = (r_count == (ADDR_W + 1)'(FIFO_DEPTH));
  assign w_pop  = o_dout_valid & i_dout_ready;
  // A full FIFO still takes the byte if the head leaves in the same cycle.
  assign w_push = w_push_req & (~w_full | w_pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_filt_sh      <= '0;
      r_filt         <= 1'b0;
      r_shift        <= '0;
      r_bitcnt       <= '0;
      r_err_parity   <= 1'b0;
      r_err_frame    <= 1'b0;
      r_err_overflow <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_state        <= w_state_next;
      r_filt_sh      <= {i_ps2c, r_filt_sh[FILTER_LEN-1:1]};
      r_filt         <= w_filt_next;
      r_shift        <= w_shift_next;
      r_bitcnt       <= w_bitcnt_next;
      r_err_parity   <= w_par_err;
      r_err_frame    <= w_frame_err;
      r_err_overflow <= w_push_req & w_full & ~w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift[8:1];
  end

  assign o_rx_idle      = (r_state == S_IDLE);
  assign o_dout_valid   = (r_count != '0);
  assign o_dout         = o_dout_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_fifo_count   = r_count;
  assign o_err_parity   = r_err_parity;
  assign o_err_frame    = r_err_frame;
  assign o_err_overflow = r_err_overflow;
endmodule
